md5_msg_gen: RTL and testbench

MD5_MSG_GEN -- requirements
Module: md5_msg_gen

---
 rtl/md5_pkg.sv | 28 ++
 rtl/md5_pad.sv | 23 ++
 rtl/md5_msg_gen.sv | 153 +++++++++++++++
 tb/tb_md5_msg_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared MD5 constants, FSM state type and block word/byte addressing helpers.
package md5_pkg;

    localparam int unsigned MD5_BLOCK_W = 512;
    localparam int unsigned MD5_WORD_W  = 32;

    localparam logic [31:0] MD5_A = 32'h67452301;
    localparam logic [31:0] MD5_B = 32'hefcdab89;
    localparam logic [31:0] MD5_C = 32'h98badcfe;
    localparam logic [31:0] MD5_D = 32'h10325476;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word w of a block lives at the top end: word 0 is bits [511:480].
    function automatic logic [31:0] md5_word(input logic [511:0] blk, input int unsigned w);
        return blk[511 - 32*w -: 32];
    endfunction

    // Little-endian byte j inside its word, expressed as a block bit offset.
    function automatic int unsigned md5_byte_lsb(input int unsigned j);
        return MD5_BLOCK_W - MD5_WORD_W - MD5_WORD_W*(j/4) + 8*(j%4);
    endfunction

endpackage

// File: rtl/md5_pad.sv
// Builds the single padded MD5 block for a short key from its digit vector.
module md5_pad
    import md5_pkg::*;
#(
    parameter int unsigned KEY_LEN   = 4,
    parameter logic [7:0]  CHAR_BASE = 8'h61,
    parameter int unsigned DIGIT_W   = 5
) (
    input  logic [KEY_LEN*DIGIT_W-1:0] digits,
    output logic [MD5_BLOCK_W-1:0]     block
);

    always_comb begin
        block = '0;
        for (int unsigned j = 0; j < KEY_LEN; j++) begin
            block[md5_byte_lsb(j) +: 8] = CHAR_BASE + 8'(digits[j*DIGIT_W +: DIGIT_W]);
        end
        block[md5_byte_lsb(KEY_LEN) +: 8] = 8'h80;
        // Word 14 carries the message length in bits.
        block[md5_byte_lsb(56) +: 32] = 32'(KEY_LEN*8);
    end

endmodule

// File: rtl/md5_msg_gen.sv
// Enumerates every KEY_LEN-character candidate key and presents each one as
// a padded MD5 block with initial chaining values to a downstream round pipeline.
module md5_msg_gen
    import md5_pkg::*;
#(
    parameter int unsigned KEY_LEN   = 4,
    parameter logic [7:0]  CHAR_BASE = 8'h61,
    parameter int unsigned RADIX     = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         ready,
    output logic         valid,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic [511:0] m_out,
    output logic [39:0]  idx_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned DIGIT_W = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam int unsigned IDX_W   = 40;
    localparam int unsigned DIGS_W  = KEY_LEN * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);

    state_t                   state_q, state_d;
    logic [DIGS_W-1:0]        digits_q, digits_d, digits_inc;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [MD5_BLOCK_W-1:0]   m_q, m_d, pad_block;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     xfer;
    logic                     last;
    logic                     carry;
    logic                     clear;

    assign xfer = valid_q & ready;

    // Ripple increment of the digit vector; last flags the all-max candidate.
    always_comb begin
        digits_inc = digits_q;
        carry      = 1'b1;
        last       = 1'b1;
        for (int unsigned i = 0; i < KEY_LEN; i++) begin
            if (digits_q[i*DIGIT_W +: DIGIT_W] != DIGIT_MAX) begin
                last = 1'b0;
            end
            if (carry) begin
                if (digits_q[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX) begin
                    digits_inc[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    digits_inc[i*DIGIT_W +: DIGIT_W] = digits_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop has priority over start and over reaching the last candidate.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start && !stop) state_d = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (xfer && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clear = (state_q != ST_RUN) && (state_d == ST_RUN);

    always_comb begin
        valid_d  = (state_d == ST_RUN);
        busy_d   = (state_d == ST_RUN);
        done_d   = (state_d == ST_DONE);
        digits_d = digits_q;
        idx_d    = idx_q;
        if (clear) begin
            digits_d = '0;
            idx_d    = '0;
        end else if (xfer) begin
            digits_d = digits_inc;
            idx_d    = idx_q + IDX_W'(1);
        end
    end

    md5_pad #(
        .KEY_LEN   (KEY_LEN),
        .CHAR_BASE (CHAR_BASE),
        .DIGIT_W   (DIGIT_W)
    ) u_pad (
        .digits (digits_d),
        .block  (pad_block)
    );

    // The block is re-registered only when the candidate changes, so it holds under backpressure.
    assign m_d = (clear || xfer) ? pad_block : m_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= '0;
            idx_q    <= '0;
            m_q      <= '0;
        end else begin
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            digits_q <= digits_d;
            idx_q    <= idx_d;
            m_q      <= m_d;
        end
    end

    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign idx_out = idx_q;
    assign m_out   = m_q;
    assign a_out   = MD5_A;
    assign b_out   = MD5_B;
    assign c_out   = MD5_C;
    assign d_out   = MD5_D;

endmodule

// File: tb/tb_md5_msg_gen.sv
// Random and directed checks of md5_msg_gen (KEY_LEN=4 and KEY_LEN=3) against a behavioural model.
module tb_md5_msg_gen;

    logic clk;
    logic rst_n;
    logic start;
    logic stop;
    logic ready;

    logic         valid_o [2];
    logic         busy_o  [2];
    logic         done_o  [2];
    logic [31:0]  a_o     [2];
    logic [31:0]  b_o     [2];
    logic [31:0]  c_o     [2];
    logic [31:0]  d_o     [2];
    logic [511:0] m_o     [2];
    logic [39:0]  idx_o   [2];

    int total = 0;
    int bad   = 0;

    int    klen   [2] = '{4, 3};
    longint n_cand [2] = '{64'd456976, 64'd17576};
    bit    m_run  [2];
    bit    m_done [2];
    longint m_idx [2];

    md5_msg_gen #(.KEY_LEN(4), .CHAR_BASE(8'h61), .RADIX(26)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_o[0]), .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]), .d_out(d_o[0]),
        .m_out(m_o[0]), .idx_out(idx_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    md5_msg_gen #(.KEY_LEN(3), .CHAR_BASE(8'h61), .RADIX(26)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ready(ready),
        .valid(valid_o[1]), .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]), .d_out(d_o[1]),
        .m_out(m_o[1]), .idx_out(idx_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] b, input int w);
        return b[511 - 32*w -: 32];
    endfunction

    function automatic logic [511:0] put_byte(input logic [511:0] b, input int j, input logic [7:0] v);
        logic [511:0] r = b;
        logic [31:0]  w = b[511 - 32*(j/4) -: 32];
        w[8*(j%4) +: 8] = v;
        r[511 - 32*(j/4) -: 32] = w;
        return r;
    endfunction

    // Expected block derived from the index by base-26 decomposition.
    function automatic logic [511:0] ref_block(input longint idx, input int kl);
        logic [511:0] b = '0;
        longint v = idx;
        int d;
        for (int j = 0; j < kl; j++) begin
            d = int'(v % 26);
            v = v / 26;
            b = put_byte(b, j, 8'(32'h61 + d));
        end
        b = put_byte(b, kl, 8'h80);
        b[511 - 32*14 -: 32] = 32'(kl * 8);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_done[i] = 1'b0; m_idx[i] = 0;
        end
    endtask

    task automatic model_clk();
        bit xf;
        for (int i = 0; i < 2; i++) begin
            xf = m_run[i] && ready;
            if (m_run[i]) begin
                if (stop) begin
                    m_run[i] = 1'b0;
                end else if (xf) begin
                    if (m_idx[i] == n_cand[i] - 1) begin
                        m_run[i] = 1'b0; m_done[i] = 1'b1;
                    end else begin
                        m_idx[i]++;
                    end
                end
            end else if (!stop && start) begin
                m_run[i] = 1'b1; m_done[i] = 1'b0; m_idx[i] = 0;
            end else if (stop) begin
                m_done[i] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("k%0d_valid", klen[i]), 512'(valid_o[i]), 512'(m_run[i]));
            chk($sformatf("k%0d_busy", klen[i]),  512'(busy_o[i]),  512'(m_run[i]));
            chk($sformatf("k%0d_done", klen[i]),  512'(done_o[i]),  512'(m_done[i]));
            chk($sformatf("k%0d_a", klen[i]), 512'(a_o[i]), 512'(32'h67452301));
            chk($sformatf("k%0d_b", klen[i]), 512'(b_o[i]), 512'(32'hefcdab89));
            chk($sformatf("k%0d_c", klen[i]), 512'(c_o[i]), 512'(32'h98badcfe));
            chk($sformatf("k%0d_d", klen[i]), 512'(d_o[i]), 512'(32'h10325476));
            if (m_run[i]) begin
                chk($sformatf("k%0d_idx", klen[i]), 512'(idx_o[i]), 512'(m_idx[i]));
                chk($sformatf("k%0d_blk", klen[i]), m_o[i], ref_block(m_idx[i], klen[i]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_to_done();
        bit seen_last = 1'b0;
        for (int k = 0; k < 25000 && !m_done[1]; k++) begin
            ready = ($urandom_range(0, 7) != 0);
            step();
            if (m_run[1] && m_idx[1] == 17575 && !seen_last) begin
                seen_last = 1'b1;
                chk("k3_last_word0", 512'(word_of(m_o[1], 0)), 512'(32'h807a7a7a));
            end
        end
        ready = 1'b1;
        chk("k3_done_reached", 512'(done_o[1]), 512'(1'b1));
    endtask

    task automatic check_reset_values();
        model_reset();
        check_outputs();
        chk("k4_m_reset", m_o[0], 512'(0));
        chk("k3_m_reset", m_o[1], 512'(0));
        chk("k4_idx_reset", 512'(idx_o[0]), 512'(0));
        chk("k3_idx_reset", 512'(idx_o[1]), 512'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
        #2;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First blocks with ready held high.
        ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("k4_first_w0",  512'(word_of(m_o[0], 0)),  512'(32'h61616161));
        chk("k4_first_w1",  512'(word_of(m_o[0], 1)),  512'(32'h00000080));
        chk("k4_first_w14", 512'(word_of(m_o[0], 14)), 512'(32'h00000020));
        chk("k4_first_w2",  512'(word_of(m_o[0], 2)),  512'(0));
        chk("k4_first_idx", 512'(idx_o[0]), 512'(0));
        chk("k3_first_w0",  512'(word_of(m_o[1], 0)),  512'(32'h80616161));
        chk("k3_first_w14", 512'(word_of(m_o[1], 14)), 512'(32'h00000018));
        step();
        chk("k4_second_w0", 512'(word_of(m_o[0], 0)), 512'(32'h61616162));
        repeat (25) step();
        chk("k4_blk26_idx", 512'(idx_o[0]), 512'(26));
        chk("k4_blk26_w0",  512'(word_of(m_o[0], 0)), 512'(32'h61616261));

        // Random backpressure, then a 5-cycle ready stall.
        repeat (300) begin
            ready = 1'($urandom_range(0, 1));
            step();
        end
        ready = 1'b0;
        repeat (5) step();
        ready = 1'b1;
        repeat (3) step();

        // Stop at index 100, simultaneous start/stop, then restart.
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        repeat (100) step();
        chk("k4_at_100", 512'(idx_o[0]), 512'(100));
        stop = 1'b1; step(); stop = 1'b0;
        chk("k4_stop_valid", 512'(valid_o[0]), 512'(0));
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("k4_startstop_valid", 512'(valid_o[0]), 512'(0));
        start = 1'b1; step(); start = 1'b0;
        chk("k4_restart_idx", 512'(idx_o[0]), 512'(0));

        // Full KEY_LEN=3 enumeration, DONE->RUN, second enumeration, DONE->IDLE.
        run_to_done();
        repeat (2) step();
        start = 1'b1; step(); start = 1'b0;
        chk("k3_rerun_valid", 512'(valid_o[1]), 512'(1));
        chk("k3_rerun_idx",   512'(idx_o[1]),   512'(0));
        run_to_done();
        stop = 1'b1; step(); stop = 1'b0;
        chk("k3_done_stop", 512'(done_o[1]), 512'(0));

        // Asynchronous reset in the middle of a run.
        start = 1'b1; step(); start = 1'b0;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Random control traffic.
        repeat (2000) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            ready = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0; stop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
